// File: rtl/wide_bram_read_arbiter.sv
// Two-requester burst read arbiter for the wide BRAM read port.
// Round-robin by default; define WIDE_BRAM_ARB_FIXED_PRIORITY_EN for fixed priority to requester 0.
module wide_bram_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LEN_WIDTH-1:0]  req0_len,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic                  rsp0_last,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LEN_WIDTH-1:0]  req1_len,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic                  rsp1_last,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] mem_dout_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [LEN_WIDTH-1:0]  remain;
  logic                  owner;
  logic                  p_valid;
  logic                  p_owner;
  logic                  p_last;
  logic                  winner;
  logic                  accept;
`ifndef WIDE_BRAM_ARB_FIXED_PRIORITY_EN
  logic                  last_grant;
`endif

  // Winner selection; only meaningful when accept is high
  always_comb begin
    winner = 1'b0;
`ifdef WIDE_BRAM_ARB_FIXED_PRIORITY_EN
    winner = ~req0_valid;
`else
    if (req0_valid && req1_valid) winner = ~last_grant;
    else                          winner = ~req0_valid;
`endif
  end

  // No grant while reset is asserted, so a request cannot slip past an abort
  assign accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
  assign req0_ready = accept && !winner;
  assign req1_ready = accept &&  winner;

  // Address is live during BURST and held at the last issued value otherwise
  assign mem_dout_addr = (state == BURST) ? cur_addr : hold_addr;

  assign rsp0_valid = p_valid && !p_owner;
  assign rsp1_valid = p_valid &&  p_owner;
  assign rsp0_last  = rsp0_valid && p_last;
  assign rsp1_last  = rsp1_valid && p_last;
  assign rsp0_data  = mem_dout;
  assign rsp1_data  = mem_dout;
  assign busy       = (state == BURST) || p_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      hold_addr <= '0;
      remain    <= '0;
      owner     <= 1'b0;
      p_valid   <= 1'b0;
      p_owner   <= 1'b0;
      p_last    <= 1'b0;
`ifndef WIDE_BRAM_ARB_FIXED_PRIORITY_EN
      last_grant <= 1'b1;
`endif
    end else begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr <= winner ? req1_addr : req0_addr;
            remain   <= winner ? req1_len  : req0_len;
            owner    <= winner;
            state    <= BURST;
`ifndef WIDE_BRAM_ARB_FIXED_PRIORITY_EN
            last_grant <= winner;
`endif
          end
        end
        BURST: begin
          // One word issued per cycle; its data returns next cycle via the p_* flags
          hold_addr <= cur_addr;
          cur_addr  <= cur_addr + ADDR_WIDTH'(1);
          p_valid   <= 1'b1;
          p_owner   <= owner;
          p_last    <= (remain == '0);
          if (remain == '0) state  <= IDLE;
          else              remain <= remain - LEN_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_bram_read_arbiter.sv
// Scoreboard bench for wide_bram_read_arbiter: a registered memory model plus per-scenario timing checks.
module tb_wide_bram_read_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 4;

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [LW-1:0] req0_len, req1_len;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp0_last, rsp1_valid, rsp1_last;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [AW-1:0] mem_dout_addr;
  logic [DW-1:0] mem_dout;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          owner;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t sbq[$];

  wide_bram_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_last(rsp0_last), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_last(rsp1_last), .rsp1_data(rsp1_data),
    .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {32'hC0DE_0000 + 32'(a), 32'h5A5A_5A5A ^ {a, 22'h0}};
  endfunction

  // Registered-read memory model
  always @(posedge clk) mem_dout <= word_of(mem_dout_addr);

  // Scoreboard: push on accept, pop and compare on every response word
  always @(negedge clk) begin
    exp_t e;
    logic [DW-1:0] got_data;
    if (req0_valid && req0_ready)
      for (int i = 0; i <= int'(req0_len); i++)
        sbq.push_back('{1'b0, req0_addr + AW'(i), (i == int'(req0_len))});
    if (req1_valid && req1_ready)
      for (int i = 0; i <= int'(req1_len); i++)
        sbq.push_back('{1'b1, req1_addr + AW'(i), (i == int'(req1_len))});
    if (rsp0_valid || rsp1_valid) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_rsp got v0=%b v1=%b required none", rsp0_valid, rsp1_valid);
      end else begin
        e = sbq.pop_front();
        got_data = e.owner ? rsp1_data : rsp0_data;
        if ({rsp0_valid, rsp0_last, rsp1_valid, rsp1_last} !==
              {!e.owner, !e.owner && e.last, e.owner, e.owner && e.last} ||
            got_data !== word_of(e.addr)) begin
          bad++;
          $display("FAIL sb_rsp addr=%0h got v0=%b l0=%b v1=%b l1=%b data=%0h required owner=%b last=%b data=%0h",
                   e.addr, rsp0_valid, rsp0_last, rsp1_valid, rsp1_last, got_data,
                   e.owner, e.last, word_of(e.addr));
        end
      end
    end
    if (reset) sbq.delete();
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_len = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_len = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL drain_busy got=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp0_last, rsp1_valid, rsp1_last, busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b required=0000000",
               {req0_ready, req1_ready, rsp0_valid, rsp0_last, rsp1_valid, rsp1_last, busy});
    end
    total++;
    if (mem_dout_addr !== AW'(0)) begin
      bad++;
      $display("FAIL reset_addr got=%0h required=0", mem_dout_addr);
    end
  endtask

  task automatic test_single_burst();
    logic [AW-1:0] exp_addr;
    tick();
    req0_valid = 1'b1; req0_addr = AW'('h10); req0_len = LW'(3);
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_accept got=%b required=10", {req0_ready, req1_ready});
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      exp_addr = (k <= 4) ? AW'('h10 + k - 1) : AW'('h13);
      total++;
      if (mem_dout_addr !== exp_addr) begin
        bad++;
        $display("FAIL single_addr k=%0d got=%0h required=%0h", k, mem_dout_addr, exp_addr);
      end
      total++;
      if ({rsp0_valid, rsp0_last, rsp1_valid, busy} !== {(k >= 2 && k <= 5), (k == 5), 1'b0, (k <= 5)}) begin
        bad++;
        $display("FAIL single_flags k=%0d got=%b required=%b", k, {rsp0_valid, rsp0_last, rsp1_valid, busy},
                 {(k >= 2 && k <= 5), (k == 5), 1'b0, (k <= 5)});
      end
      if (k == 2) begin
        total++;
        if (rsp0_data !== word_of(AW'('h10))) begin
          bad++;
          $display("FAIL single_first_data got=%0h required=%0h", rsp0_data, word_of(AW'('h10)));
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [5];
`ifdef WIDE_BRAM_ARB_FIXED_PRIORITY_EN
    exp_grant = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`else
    exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`endif
    tick();
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = AW'('h20); req0_len = '0;
    req1_valid = 1'b1; req1_addr = AW'('h30); req1_len = '0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({req1_ready, req0_ready} !== exp_grant[c]) begin
        bad++;
        $display("FAIL contention_grant c=%0d got=%b required=%b", c, {req1_ready, req0_ready}, exp_grant[c]);
      end
      tick();
    end
    idle_inputs();
    drain();
  endtask

  task automatic test_wrap();
    tick();
    req1_valid = 1'b1; req1_addr = '1; req1_len = LW'(1);
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      bad++;
      $display("FAIL wrap_accept got=%b required=10", {req1_ready, req0_ready});
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_dout_addr !== {AW{1'b1}}) begin
      bad++;
      $display("FAIL wrap_addr0 got=%0h required=%0h", mem_dout_addr, {AW{1'b1}});
    end
    tick();
    @(negedge clk);
    total++;
    if (mem_dout_addr !== AW'(0) || {rsp1_valid, rsp1_last} !== 2'b10) begin
      bad++;
      $display("FAIL wrap_addr1 got addr=%0h v/l=%b required addr=0 v/l=10", mem_dout_addr, {rsp1_valid, rsp1_last});
    end
    tick();
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp1_last, rsp0_valid} !== 3'b110) begin
      bad++;
      $display("FAIL wrap_last got=%b required=110", {rsp1_valid, rsp1_last, rsp0_valid});
    end
    drain();
  endtask

  task automatic test_reset_mid();
    tick();
    req0_valid = 1'b1; req0_addr = AW'('h40); req0_len = LW'(7);
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_accept got=%b required=1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mem_dout_addr !== AW'('h42)) begin
      bad++;
      $display("FAIL midrst_third_issue got=%0h required=42", mem_dout_addr);
    end
    tick();
    reset = 1'b0;
    req1_valid = 1'b1; req1_addr = AW'('h50); req1_len = '0;
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid, busy, req1_ready} !== 4'b0001 || mem_dout_addr !== AW'(0)) begin
      bad++;
      $display("FAIL midrst_after got v0/v1/busy/rdy1=%b addr=%0h required 0001 addr=0",
               {rsp0_valid, rsp1_valid, busy, req1_ready}, mem_dout_addr);
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_dout_addr !== AW'('h50)) begin
      bad++;
      $display("FAIL midrst_new_addr got=%0h required=50", mem_dout_addr);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    tick();
    req0_valid = 1'b1; req0_addr = AW'('h60); req0_len = '0;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept0 got=%b required=1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = AW'('h70); req1_len = '0;
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready_in_burst got=%b required=0", req1_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if ({req1_ready, rsp0_valid, rsp0_last} !== 3'b111) begin
      bad++;
      $display("FAIL b2b_overlap got=%b required=111", {req1_ready, rsp0_valid, rsp0_last});
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_gap got=%b required=00", {rsp0_valid, rsp1_valid});
    end
    tick();
    @(negedge clk);
    total++;
    if ({rsp1_valid, rsp1_last, rsp0_valid} !== 3'b110) begin
      bad++;
      $display("FAIL b2b_rsp1 got=%b required=110", {rsp1_valid, rsp1_last, rsp0_valid});
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_burst();
    test_contention();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    tick();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
